fft_result_buffer: RTL and testbench
====================================

# fft_result_buffer

Frame buffer between the FFT core output and `avalonMaster`. Captures one frame of 512 16-bit FFT result samples from a valid/ready stream into local storage. Pulses `fft_done` when the frame is complete, then serves `avalonMaster` random-access reads (`sReEn`, `sampled_master_address`, `sampled_data`) until it has read the last address. It then re-arms for the next frame.

## Interface
- `DATA_W`, 16, sample width; must match `avalonMaster` `sampled_data`.
- `ADDR_W`, 9, address width; buffer depth is `DEPTH = 2**ADDR_W` (512).
- `clk`  in  1  system clock; all logic rising-edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  FFT core presents a sample.
- `in_data`  in  DATA_W  sample value.
- `in_ready`  out  1  buffer accepts a sample; a write occurs when `in_valid & in_ready`.
- `fft_done`  out  1  single-cycle pulse: frame captured, ready to drain.
- `sReEn`  in  1  read enable from `avalonMaster`.
- `sampled_master_address`  in  ADDR_W  read address.
- `sampled_data`  out  DATA_W  registered read data.
- `overrun`  out  1  sticky: `in_valid` was seen while `in_ready` was low; cleared only by reset.

## Operation
- Storage: DEPTH x DATA_W array with one write port and one read port. No reset of contents.
- Write counter `wcnt` (ADDR_W bits) counts accepted samples within the frame.
- FSM states:
  - FILL: `in_ready=1`. Each accepted sample is written at `waddr(wcnt)` and `wcnt` increments. Accepting the sample with `wcnt==DEPTH-1` moves to DONE and wraps `wcnt` to 0.
  - DONE: `in_ready=0`, `fft_done=1`. Lasts exactly one cycle, then moves to DRAIN.
  - DRAIN: `in_ready=0`. Waits for a read with `sReEn=1` and `sampled_master_address==DEPTH-1`, then moves to FILL.
- Reads are served in every state. `sampled_data` loads `mem[sampled_master_address]` when `sReEn=1` and holds its value otherwise. Reads in FILL return stale or partial-frame data by design.
- Drain reads may come in any order and may repeat. Only a read of address DEPTH-1 while in DRAIN ends the frame.
- `in_valid` outside FILL: the sample is dropped, the counter does not change, and `overrun` is set.
- `waddr(wcnt)`: see Configuration.

## Timing
- Reset values: state=FILL, `wcnt=0`, `in_ready=1`, `fft_done=0`, `sampled_data=0`, `overrun=0`.
- Write latency: a sample accepted at edge N is readable by a read sampled at edge N+1 or later.
- Read latency: `sampled_data` is valid 1 cycle after the edge that samples `sReEn=1`.
- Frame latency: `fft_done` is high in the cycle immediately after the edge that accepts sample DEPTH-1. `in_ready` falls in that same cycle.
- Drain exit: the last-address read is sampled at edge M. Its data appears after M, and `in_ready=1` from the cycle after M. A sample can be accepted at edge M+1.
- Read/write to the same address in the same cycle cannot occur in DRAIN. In FILL the read returns old contents (read-before-write).
- Reset mid-operation (any state): the FSM returns to FILL, `wcnt` is cleared, and any `fft_done` pulse in progress is cancelled. The next frame needs a full DEPTH samples.
- `in_ready` is a registered-state decode only. It has no combinational path from `in_valid`.

## Configuration
- `FFT_BUF_BITREV_EN`:
  - Defined: `waddr` is the ADDR_W-bit bit-reversal of `wcnt`, so the natural-order FFT output lands in frequency order.
  - Undefined: `waddr = wcnt`, which stores samples in arrival order.
- Read addressing is unaffected in both cases.

## Test plan
- Reset, then stream 512 samples with `in_data=i`, `in_valid` held high → `in_ready` drops and `fft_done` is high for exactly 1 cycle after sample 511 is accepted. Without the macro, reading address 5 gives `sampled_data=5` one cycle later.
- Same stream with `FFT_BUF_BITREV_EN` → reading address 1 gives 256, and address 511 gives 511.
- In DRAIN, hold `in_valid=1` with `in_data=16'hBEEF` → no write, `overrun=1`. Re-reading address 0 still gives 0.
- Read addresses 0..511 in order, then 10 → FSM back in FILL with `in_ready=1` the cycle after the address-511 read. The address-10 read still returns 10.
- Assert `n_rst` low after 100 samples, release, then stream 511 samples → no `fft_done`. The 512th sample produces the pulse.
- `sReEn=0` with a changing address → `sampled_data` holds its last value.

Source files
------------

// File: rtl/fft_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_buffer
// Purpose  : Captures one 512-sample FFT frame, pulses fft_done, then serves
//            random-access reads until the last address is read.
//            Optional macro FFT_BUF_BITREV_EN stores samples bit-reversed.
// Revision : 1.0  initial release
// ============================================================================
module fft_result_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fft_done,
    input  logic              sReEn,
    input  logic [ADDR_W-1:0] sampled_master_address,
    output logic [DATA_W-1:0] sampled_data,
    output logic              overrun
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DONE  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                overrun_q, overrun_d;
    logic [ADDR_W-1:0]   waddr;
    logic                wr_en;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef FFT_BUF_BITREV_EN
    always_comb begin
        waddr = '0;
        for (int k = 0; k < ADDR_W; k++) begin
            waddr[k] = wcnt_q[ADDR_W-1-k];
        end
    end
`else
    assign waddr = wcnt_q;
`endif

    assign in_ready     = (state_q == FILL);
    assign fft_done     = (state_q == DONE);
    assign sampled_data = rdata_q;
    assign overrun      = overrun_q;
    assign wr_en        = in_valid && (state_q == FILL);

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rdata_d   = rdata_q;
        overrun_d = overrun_q;
        if (sReEn) begin
            rdata_d = mem[sampled_master_address];
        end
        if (in_valid && (state_q != FILL)) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_ADDR) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = DRAIN;
            DRAIN: begin
                if (sReEn && (sampled_master_address == LAST_ADDR)) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= FILL;
            wcnt_q    <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_result_buffer
// Purpose  : Directed self-checking bench for fft_result_buffer.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_result_buffer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        fft_done;
    logic        sReEn = 1'b0;
    logic [8:0]  sampled_master_address = '0;
    logic [15:0] sampled_data;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt;

    fft_result_buffer #(.DATA_W(16), .ADDR_W(9)) dut (
        .clk                    (clk),
        .n_rst                  (n_rst),
        .in_valid               (in_valid),
        .in_data                (in_data),
        .in_ready               (in_ready),
        .fft_done               (fft_done),
        .sReEn                  (sReEn),
        .sampled_master_address (sampled_master_address),
        .sampled_data           (sampled_data),
        .overrun                (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample index whose value lands at read address a.
    function automatic logic [15:0] map_addr(input int a);
        logic [8:0] v;
        logic [8:0] r;
        v = a[8:0];
        r = v;
`ifdef FFT_BUF_BITREV_EN
        for (int k = 0; k < 9; k++) r[k] = v[8-k];
`endif
        return {7'd0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int a);
        sReEn = 1'b1;
        sampled_master_address = a[8:0];
        step();
        sReEn = 1'b0;
    endtask

    task automatic stream(input int first, input int last, input int base);
        int v;
        done_cnt = 0;
        for (int i = first; i <= last; i++) begin
            v = base + i;
            in_valid = 1'b1;
            in_data  = v[15:0];
            step();
            if (fft_done && i != last) done_cnt++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int v;
        // Reset state
        #2;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_fft_done", {31'd0, fft_done}, 32'd0);
        check_eq("rst_data", {16'd0, sampled_data}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        step();
        n_rst = 1'b1;
        step();

        // Frame 1: data = index
        stream(0, 511, 0);
        check_eq("f1_early_done", done_cnt, 32'd0);
        check_eq("f1_done_pulse", {31'd0, fft_done}, 32'd1);
        check_eq("f1_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        check_eq("f1_done_one_cycle", {31'd0, fft_done}, 32'd0);
        check_eq("f1_drain_ready", {31'd0, in_ready}, 32'd0);

        rd(5);
        check_eq("rd5", {16'd0, sampled_data}, {16'd0, map_addr(5)});
        rd(1);
        check_eq("rd1", {16'd0, sampled_data}, {16'd0, map_addr(1)});
        check_eq("no_overrun_yet", {31'd0, overrun}, 32'd0);

        // Input while draining is dropped and flagged
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        step(); step(); step();
        in_valid = 1'b0;
        check_eq("overrun_set", {31'd0, overrun}, 32'd1);
        check_eq("overrun_ready", {31'd0, in_ready}, 32'd0);
        rd(0);
        check_eq("rd0_after_overrun", {16'd0, sampled_data}, 32'd0);

        // Hold when sReEn is low
        rd(7);
        sampled_master_address = 9'd3;
        step();
        sampled_master_address = 9'd100;
        step();
        check_eq("hold_data", {16'd0, sampled_data}, {16'd0, map_addr(7)});

        // Full drain in order
        for (int a = 0; a < 511; a++) begin
            rd(a);
            check_eq("drain_data", {16'd0, sampled_data}, {16'd0, map_addr(a)});
            check_eq("drain_ready", {31'd0, in_ready}, 32'd0);
        end
        rd(511);
        check_eq("rd511", {16'd0, sampled_data}, {16'd0, map_addr(511)});
        check_eq("exit_ready", {31'd0, in_ready}, 32'd1);
        rd(10);
        check_eq("rd10_after_exit", {16'd0, sampled_data}, {16'd0, map_addr(10)});
        check_eq("fill_ready", {31'd0, in_ready}, 32'd1);

        // Partial frame, then asynchronous reset mid-frame
        stream(0, 99, 1000);
        check_eq("partial_no_done", done_cnt + {31'd0, fft_done}, 32'd0);
        n_rst = 1'b0;
        #1;
        check_eq("midrst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_overrun", {31'd0, overrun}, 32'd0);
        check_eq("midrst_data", {16'd0, sampled_data}, 32'd0);
        step();
        n_rst = 1'b1;
        step();

        // First sample of new frame collides with a read of the same word
        sReEn = 1'b1;
        sampled_master_address = 9'd0;
        in_valid = 1'b1;
        in_data  = 16'd2000;
        step();
        sReEn = 1'b0;
        in_valid = 1'b0;
        check_eq("rbw_old_data", {16'd0, sampled_data}, 32'd1000);

        stream(1, 510, 2000);
        check_eq("f2_511_no_done", done_cnt + {31'd0, fft_done}, 32'd0);
        check_eq("f2_511_ready", {31'd0, in_ready}, 32'd1);
        stream(511, 511, 2000);
        check_eq("f2_done_pulse", {31'd0, fft_done}, 32'd1);
        step();
        rd(2);
        v = 2000 + int'(map_addr(2));
        check_eq("f2_rd2", {16'd0, sampled_data}, v);
        rd(511);
        v = 2000 + int'(map_addr(511));
        check_eq("f2_rd511", {16'd0, sampled_data}, v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
